// File: rtl/move_seq_serializer.sv
// move_seq_serializer
//
// Takes one 8-bit block of four 2-bit moves per valid/ready handshake and
// streams the moves out one per cycle, move 0 (bits [1:0]) first. One block
// is held in the current register while a second can be prefetched, so
// back-to-back blocks stream with no bubble. The top two bits of the most
// recently accepted block are returned on restrected to steer the
// generator's next block.
//
// Build option: define MOVE_REPEAT_CHECK_EN to enable the sticky repeat
// detector on repeat_err. Without it, repeat_err is tied to 0.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   seq_in      in   [7:0] move block, move k = seq_in[2k+1:2k]
//   seq_valid   in   seq_in valid
//   seq_ready   out  block can be accepted (prefetch slot free)
//   restrected  out  [1:0] bits [7:6] of the last accepted block
//   move        out  [1:0] current move
//   move_valid  out  move is valid
//   move_ready  in   consumer accepts move
//   move_last   out  current move is move 3 of its block
//   blk_cnt     out  [CNT_W-1:0] blocks fully emitted (wrapping)
//   repeat_err  out  sticky: a transferred move equalled the previous one
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | nothing held, ready for a block
// ST_RUN   | current block emitting, prefetch slot free
// ST_FULL  | current block emitting, prefetch slot full

module move_seq_serializer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       seq_in,
    input  logic             seq_valid,
    output logic             seq_ready,
    output logic [1:0]       restrected,
    output logic [1:0]       move,
    output logic             move_valid,
    input  logic             move_ready,
    output logic             move_last,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             repeat_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [7:0]       r_cur;
    logic [7:0]       r_pf;
    logic [1:0]       r_idx;
    logic [1:0]       r_restrected;
    logic [CNT_W-1:0] r_blk_cnt;

    logic             w_cur_full;
    logic             w_pf_full;
    logic             w_accept;
    logic             w_xfer;
    logic             w_last_xfer;
    logic             w_load_cur_in;
    logic             w_load_cur_pf;
    logic             w_load_pf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_last_xfer && !w_accept)      w_state_nxt = ST_EMPTY;
                else if (!w_last_xfer && w_accept) w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (w_last_xfer && !w_accept) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output / handshake decode; everything here depends on registered state only
    always_comb begin
        w_cur_full = (r_state == ST_RUN) || (r_state == ST_FULL);
        w_pf_full  = (r_state == ST_FULL);
        seq_ready  = !w_pf_full;
        move_valid = w_cur_full;
        move_last  = w_cur_full && (r_idx == 2'd3);
        case (r_idx)
            2'd0:    move = r_cur[1:0];
            2'd1:    move = r_cur[3:2];
            2'd2:    move = r_cur[5:4];
            default: move = r_cur[7:6];
        endcase
    end

    assign w_accept    = seq_valid && seq_ready;
    assign w_xfer      = move_valid && move_ready;
    assign w_last_xfer = w_xfer && (r_idx == 2'd3);

    // A fresh block bypasses the prefetch slot when the current register is
    // empty or is vacating this cycle with nothing waiting behind it.
    assign w_load_cur_in = w_accept && (!w_cur_full || (w_last_xfer && !w_pf_full));
    assign w_load_cur_pf = w_last_xfer && w_pf_full;
    assign w_load_pf     = w_accept && !w_load_cur_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur        <= 8'd0;
            r_pf         <= 8'd0;
            r_idx        <= 2'd0;
            r_restrected <= 2'd0;
            r_blk_cnt    <= '0;
        end else begin
            if (w_load_cur_pf) begin
                r_cur <= r_pf;
            end else if (w_load_cur_in) begin
                r_cur <= seq_in;
            end

            if (w_load_pf) begin
                r_pf <= seq_in;
            end

            if (w_load_cur_pf || w_load_cur_in) begin
                r_idx <= 2'd0;
            end else if (w_xfer) begin
                r_idx <= r_idx + 2'd1;
            end

            if (w_accept) begin
                r_restrected <= seq_in[7:6];
            end

            if (w_last_xfer) begin
                r_blk_cnt <= r_blk_cnt + CNT_W'(1);
            end
        end
    end

    assign restrected = r_restrected;
    assign blk_cnt    = r_blk_cnt;

`ifdef MOVE_REPEAT_CHECK_EN
    logic [1:0] r_prev_move;
    logic       r_has_prev;
    logic       r_repeat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_move  <= 2'd0;
            r_has_prev   <= 1'b0;
            r_repeat_err <= 1'b0;
        end else if (w_xfer) begin
            r_prev_move <= move;
            r_has_prev  <= 1'b1;
            if (r_has_prev && (move == r_prev_move)) begin
                r_repeat_err <= 1'b1;
            end
        end
    end

    assign repeat_err = r_repeat_err;
`else
    assign repeat_err = 1'b0;
`endif

endmodule

// File: tb/tb_move_seq_serializer.sv
module tb_move_seq_serializer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seq_in;
    logic        seq_valid;
    logic        seq_ready;
    logic [1:0]  restrected;
    logic [1:0]  move;
    logic        move_valid;
    logic        move_ready;
    logic        move_last;
    logic [15:0] blk_cnt;
    logic        repeat_err;

    move_seq_serializer #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seq_in     (seq_in),
        .seq_valid  (seq_valid),
        .seq_ready  (seq_ready),
        .restrected (restrected),
        .move       (move),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_last  (move_last),
        .blk_cnt    (blk_cnt),
        .repeat_err (repeat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;

    // Reference model: the pending moves in emission order, each tagged
    // with whether it closes its block. {last, move}
    logic [2:0]  q[$];
    logic [1:0]  m_restr = 2'd0;
    logic [15:0] m_blk   = 16'd0;
    bit          m_rep   = 0;
    bit          m_has_prev = 0;
    logic [1:0]  m_prev  = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_restr = 2'd0;
        m_blk = 16'd0;
        m_rep = 0;
        m_has_prev = 0;
        m_prev = 2'd0;
    endtask

    // Monitor: outputs depend only on DUT state, compared mid-cycle
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("seq_ready", {31'd0, seq_ready}, {31'd0, (q.size() <= 4)});
            chk("move_valid", {31'd0, move_valid}, {31'd0, (q.size() != 0)});
            if (q.size() != 0 && move_valid) begin
                chk("move", {30'd0, move}, {30'd0, q[0][1:0]});
                chk("move_last", {31'd0, move_last}, {31'd0, q[0][2]});
            end else begin
                chk("move_last_idle", {31'd0, move_last}, 32'd0);
            end
            chk("restrected", {30'd0, restrected}, {30'd0, m_restr});
            chk("blk_cnt", {16'd0, blk_cnt}, {16'd0, m_blk});
            chk("repeat_err", {31'd0, repeat_err}, {31'd0, m_rep});
        end
    end

    // One cycle of stimulus starting just after a falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit mr);
        bit acc;
        bit xf;
        logic [2:0] e;
        seq_valid  = v;
        seq_in     = d;
        move_ready = mr;
        acc = v && (q.size() <= 4);
        xf  = mr && (q.size() != 0);
        @(posedge clk);
        if (xf) begin
            e = q.pop_front();
            if (e[2]) m_blk++;
`ifdef MOVE_REPEAT_CHECK_EN
            if (m_has_prev && e[1:0] == m_prev) m_rep = 1;
            m_prev = e[1:0];
            m_has_prev = 1;
`endif
        end
        if (acc) begin
            for (int k = 0; k < 4; k++) q.push_back({(k == 3), d[2*k +: 2]});
            m_restr = d[7:6];
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
        chk("drained", {31'd0, move_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        seq_in = 8'h00;
        seq_valid = 1'b0;
        move_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_move_valid", {31'd0, move_valid}, 32'd0);
        chk("rst_seq_ready", {31'd0, seq_ready}, 32'd1);
        chk("rst_move", {30'd0, move}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1;

        // Reset mid-emission of 0x1B, checked before any clock edge
        step(1'b1, 8'h1B, 1'b1);
        step(1'b1, 8'hE4, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_move_valid", {31'd0, move_valid}, 32'd0);
        chk("async_rst_seq_ready", {31'd0, seq_ready}, 32'd1);
        chk("async_rst_restrected", {30'd0, restrected}, 32'd0);
        chk("async_rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
        chk("async_rst_move_last", {31'd0, move_last}, 32'd0);
        chk("async_rst_repeat_err", {31'd0, repeat_err}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;

        // Repeat-detector sequence: only the 0x1B -> 0xE4 boundary repeats
        step(1'b1, 8'h1B, 1'b1);
        step(1'b1, 8'h1E, 1'b1);
        step(1'b1, 8'h93, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h1B, 1'b1);
        step(1'b1, 8'hE4, 1'b1);
        drain();

        // Single block
        step(1'b1, 8'h1B, 1'b1);
        drain();

        // Back-to-back with seq_valid held high
        step(1'b1, 8'h1B, 1'b1);
        step(1'b1, 8'hE4, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h4E, 1'b1);
        step(1'b1, 8'h4E, 1'b1);
        drain();

        // Backpressure: fill prefetch, stall, then release
        step(1'b1, 8'hE4, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h4E, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        drain();

        // Last transfer coinciding with an accept while prefetch is empty
        step(1'b1, 8'h1B, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 1'b1);
        step(1'b1, 8'h93, 1'b1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain();

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_seq_serializer.md
# move_seq_serializer

Downstream stage of the restricted-move sequence generator. Accepts one 8-bit, four-move block per handshake and emits its 2-bit moves one per cycle, LSB-pair first, over a valid/ready stream. Returns the final move of the most recently accepted block as the `restrected` input for the generator's next block. Holds one block in flight plus one prefetched block, so back-to-back blocks stream without bubbles.

## Interface
Parameters:
- CNT_W, default 16: width of the completed-block counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- seq_in  input  8  move block; move k is seq_in[2k+1:2k], k=0..3, emitted k=0 first.
- seq_valid  input  1  seq_in is valid.
- seq_ready  output  1  block can be accepted; equals !pf_full (registered state only).
- restrected  output  2  bits [7:6] of the last accepted block; drives the generator's restricted-move select.
- move  output  2  current move.
- move_valid  output  1  move is valid.
- move_ready  input  1  consumer accepts move.
- move_last  output  1  current move is move 3 of its block.
- blk_cnt  output  CNT_W  number of blocks fully emitted; wraps modulo 2^CNT_W.
- repeat_err  output  1  sticky repeat flag; see Configuration.

## Operation
- Storage: current register `cur[7:0]` with index `idx[1:0]` and flag `cur_full`; prefetch register `pf[7:0]` with flag `pf_full`.
- Accept: `seq_valid && seq_ready` at a clock edge. Every accept sets restrected <= seq_in[7:6].
- Routing of an accepted block: it goes to `cur` with idx=0 if `cur` is empty, or if `cur` is emitting its last move and that move transfers in the same cycle while `pf` is empty. Otherwise it goes to `pf`.
- Outputs: move = cur[2*idx+1 : 2*idx], move_valid = cur_full, move_last = cur_full && idx==3.
- Transfer: `move_valid && move_ready`.
  - If idx<3: idx increments.
  - If idx==3: blk_cnt increments. Then, in priority order: `pf` moves to `cur` with idx=0 and pf_full clears (a same-cycle accept then refills `pf`); else a same-cycle accept loads `cur`; else cur_full clears.
- While move_valid=1 and move_ready=0: move, move_last and idx stay stable.
- States: EMPTY (!cur_full), RUN (cur_full, !pf_full), FULL (cur_full, pf_full).
  - EMPTY→RUN on accept.
  - RUN→FULL on accept without a last transfer.
  - FULL→RUN on a last transfer with no accept.
  - RUN→EMPTY on a last transfer with no accept.
  - FULL stays FULL on a last transfer coinciding with an accept.
- seq_in is sampled only on accept; it may change freely otherwise.

## Timing
- Reset values: cur_full=0, pf_full=0, idx=0, cur=0, pf=0, restrected=0, blk_cnt=0, repeat_err=0. So seq_ready=1, move_valid=0, move=0, move_last=0.
- Reset assertion mid-block discards `cur` and `pf` immediately (asynchronous). The first accept after release starts from idx=0.
- Latency: accept at edge N gives move_valid=1 with move 0 after edge N (visible in cycle N+1).
- Throughput: with move_ready held high and seq_valid high, one move per cycle and no bubble between blocks; a block is accepted every 4 cycles in steady state.
- restrected changes only the cycle after an accept, so the combinational generator output stays stable while seq_valid is waiting.

## Configuration
- MOVE_REPEAT_CHECK_EN defined:
  - A register tracks the last transferred move and a "has-previous" bit; both clear on reset.
  - repeat_err sets, and stays set until reset, when a transferred move equals the previous transferred move, including across block boundaries.
- Not defined: repeat_err is tied to 0 and the tracking logic is absent.

## Test plan
- Reset: assert rst_n=0 mid-emission of block 0x1B → move_valid=0, seq_ready=1, restrected=0, blk_cnt=0 in the same cycle, before any clock edge.
- Single block: accept 0x1B with move_ready=1 → moves 3,2,1,0 on the 4 cycles after accept; move_last only on the move 0 cycle; restrected=0; blk_cnt=1.
- Back-to-back: seq_valid held high with blocks 0x1B, 0xE4, 0x4E and move_ready=1 → 12 consecutive valid cycles: 3,2,1,0,0,1,2,3,2,3,0,1; restrected sequence 0,3,1.
- Backpressure: accept 0xE4, move_ready=0 for 5 cycles → move=0 held and stable, pf fills, then seq_ready=0; release → correct order, no loss.
- Simultaneous: last transfer and accept in the same cycle with pf empty → next cycle move = new block's move 0, no bubble, seq_ready stays 1.
- With MOVE_REPEAT_CHECK_EN: blocks 0x1B then 0x1E (last move 0, next move 2 — no repeat) → repeat_err=0; then 0x93 following 0x1E (0 then 3 — no repeat) → repeat_err=0; then 0xE4 after a block ending in 0 (0 then 0) → repeat_err=1 and stays 1 until reset.
